spell_dbg_ctrl: RTL and testbench

SPELL_DBG_CTRL -- requirements
Module: spell_dbg_ctrl

---
 rtl/spell_dbg_pkg.sv | 27 ++
 rtl/spell_dbg_shifter.sv | 54 +++++
 rtl/spell_dbg_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_spell_dbg_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spell_dbg_pkg.sv
// spell_dbg_pkg
// Shared types for the SPELL debug controller: the host command opcodes,
// the controller FSM states and the default width of one SPELL register.
// No ports; imported by spell_dbg_shifter and spell_dbg_ctrl.
package spell_dbg_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_STEP  = 2'd2,
        OP_RUN   = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_W,
        ST_LOAD,
        ST_DUMP,
        ST_SHIFT_R,
        ST_STEP,
        ST_RUN,
        ST_RESP
    } state_e;

endpackage

// File: rtl/spell_dbg_shifter.sv
// spell_dbg_shifter
// DATA_W-bit MSB-first shift register with a bit counter, used both to
// serialise a value towards the CPU and to assemble a value read back.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         parallel load of load_data (also clears the bit counter)
//   load_data    value to load
//   shift_en     shift one bit left, serial_in enters at the LSB
//   serial_in    incoming bit
//   data         current register contents
//   serial_out   current MSB (next bit to send)
//   done         high during the shift cycle that moves the last bit
import spell_dbg_pkg::*;

module spell_dbg_shifter #(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data,
    output logic              serial_out,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;

    // Shift register and bit counter; the counter returns to zero on the
    // last shift so every SHIFT_W/SHIFT_R phase starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_data;
            cnt  <= '0;
        end else if (shift_en) begin
            sreg <= {sreg[DATA_W-2:0], serial_in};
            cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign data       = sreg;
    assign serial_out = sreg[DATA_W-1];
    assign done       = shift_en && (cnt == LAST);

endmodule

// File: rtl/spell_dbg_ctrl.sv
// spell_dbg_ctrl
// Host-side debug controller for the SPELL CPU. Turns host commands
// (WRITE/READ/STEP/RUN) into the SPELL ui_in pin sequences and returns one
// response per command.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_op, cmd_reg, cmd_data   opcode, register select, write value
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_err           read value or {sleep,stop} status, error
//   cpu_run .. cpu_reg_sel      drive the SPELL ui_in pins
//   cpu_shift_out, cpu_sleep,
//   cpu_stop                    SPELL uo_out[3], [0], [1]
// Build option: define SPELL_DBG_TIMEOUT_EN to abort RUN after TIMEOUT
// cycles with rsp_err=1; without it RUN waits for stop/sleep forever and
// rsp_err is constant 0.
import spell_dbg_pkg::*;

module spell_dbg_ctrl #(
    parameter int          DATA_W  = DATA_W_DEFAULT,
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_reg,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              cpu_run,
    output logic              cpu_step,
    output logic              cpu_load,
    output logic              cpu_dump,
    output logic              cpu_shift_in,
    output logic [1:0]        cpu_reg_sel,
    input  logic              cpu_shift_out,
    input  logic              cpu_sleep,
    input  logic              cpu_stop
);

    state_e            state, state_next;
    logic [1:0]        reg_q;
    logic [DATA_W-1:0] rsp_data_q, rsp_next, status;
    logic              accept, rsp_load;
    logic              sh_load, sh_en, sh_sin, sh_done, sh_msb;
    logic [DATA_W-1:0] sh_data;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    spell_dbg_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (sh_load),
        .load_data  (cmd_data),
        .shift_en   (sh_en),
        .serial_in  (sh_sin),
        .data       (sh_data),
        .serial_out (sh_msb),
        .done       (sh_done)
    );

`ifdef SPELL_DBG_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit, err_next, rsp_err_q;

    // Counts cycles spent in RUN; cleared whenever the FSM is elsewhere so
    // each RUN command gets the full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_RUN) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt == TIMEOUT - 16'd1);

    // Error flag is captured together with the response value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (rsp_load) begin
            rsp_err_q <= err_next;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latched register select and the response value; the response is
    // frozen on entry to RESP so it stays stable while the host stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                reg_q <= cmd_reg;
            end
            if (rsp_load) begin
                rsp_data_q <= rsp_next;
            end
        end
    end

    // Next-state and datapath control. The command value is loaded into the
    // shifter on every acceptance; READ simply overwrites it while shifting.
    always_comb begin
        state_next = state;
        sh_load    = 1'b0;
        sh_en      = 1'b0;
        sh_sin     = 1'b0;
        rsp_load   = 1'b0;
        rsp_next   = '0;
        status     = '0;
        status[1]  = cpu_sleep;
        status[0]  = cpu_stop;
`ifdef SPELL_DBG_TIMEOUT_EN
        err_next   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    sh_load = 1'b1;
                    case (cmd_op_e'(cmd_op))
                        OP_WRITE: state_next = ST_SHIFT_W;
                        OP_READ:  state_next = ST_DUMP;
                        OP_STEP:  state_next = ST_STEP;
                        OP_RUN:   state_next = ST_RUN;
                    endcase
                end
            end
            ST_SHIFT_W: begin
                sh_en = 1'b1;
                if (sh_done) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_RESP;
                rsp_load   = 1'b1;
            end
            ST_DUMP: begin
                state_next = ST_SHIFT_R;
            end
            ST_SHIFT_R: begin
                sh_en  = 1'b1;
                sh_sin = cpu_shift_out;
                if (sh_done) begin
                    state_next = ST_RESP;
                    rsp_load   = 1'b1;
                    rsp_next   = {sh_data[DATA_W-2:0], cpu_shift_out};
                end
            end
            ST_STEP: begin
                state_next = ST_RESP;
                rsp_load   = 1'b1;
                rsp_next   = status;
            end
            ST_RUN: begin
                if (cpu_stop || cpu_sleep) begin
                    state_next = ST_RESP;
                    rsp_load   = 1'b1;
                    rsp_next   = status;
                end
`ifdef SPELL_DBG_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_next = ST_RESP;
                    rsp_load   = 1'b1;
                    err_next   = 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rsp_valid    = (state == ST_RESP);
    assign rsp_data     = rsp_data_q;
    assign cpu_run      = (state == ST_RUN);
    assign cpu_step     = (state == ST_STEP);
    assign cpu_load     = (state == ST_LOAD);
    assign cpu_dump     = (state == ST_DUMP);
    assign cpu_shift_in = (state == ST_SHIFT_W) && sh_msb;
    assign cpu_reg_sel  = (state == ST_IDLE) ? 2'b00 : reg_q;

endmodule

// File: tb/tb_spell_dbg_ctrl.sv
// tb_spell_dbg_ctrl
// Directed bench for spell_dbg_ctrl. A small CPU model answers DUMP with a
// preset value shifted out MSB first. Define SPELL_DBG_TIMEOUT_EN for both
// the DUT and the bench to exercise the RUN timeout (TIMEOUT=16).
module tb_spell_dbg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op, cmd_reg;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       cpu_run, cpu_step, cpu_load, cpu_dump, cpu_shift_in;
    logic [1:0] cpu_reg_sel;
    logic       cpu_shift_out, cpu_sleep, cpu_stop;

    int total = 0;
    int bad   = 0;
    int load_pulses  = 0;
    int overlap_hits = 0;

`ifdef SPELL_DBG_TIMEOUT_EN
    localparam int RUN_STOP_AT = 10;
`else
    localparam int RUN_STOP_AT = 20;
`endif

    logic [7:0] model_val = 8'h00;
    logic [7:0] model_sr  = 8'h00;

    spell_dbg_ctrl #(.DATA_W(8), .TIMEOUT(16'd16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_reg       (cmd_reg),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .cpu_run       (cpu_run),
        .cpu_step      (cpu_step),
        .cpu_load      (cpu_load),
        .cpu_dump      (cpu_dump),
        .cpu_shift_in  (cpu_shift_in),
        .cpu_reg_sel   (cpu_reg_sel),
        .cpu_shift_out (cpu_shift_out),
        .cpu_sleep     (cpu_sleep),
        .cpu_stop      (cpu_stop)
    );

    always #5 clk = ~clk;

    // CPU model: DUMP captures the register, then one bit leaves per clock.
    always @(posedge clk) begin
        if (cpu_dump) model_sr <= model_val;
        else          model_sr <= {model_sr[6:0], 1'b0};
    end
    assign cpu_shift_out = model_sr[7];

    // Track load pulses and any overlap of load/dump/step.
    always @(negedge clk) begin
        if (cpu_load === 1'b1) load_pulses++;
        if (int'(cpu_load) + int'(cpu_dump) + int'(cpu_step) > 1) overlap_hits++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] r, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = r;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic run_write(input logic [1:0] r, input logic [7:0] d,
                             output logic [7:0] bits, output int load_at,
                             output int resp_at, output logic sel_ok,
                             output logic sin_at_load);
        issue(2'd0, r, d);
        bits = 8'h00; load_at = -1; resp_at = -1; sel_ok = 1'b1; sin_at_load = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 8) bits = {bits[6:0], cpu_shift_in};
            if (cpu_load === 1'b1 && load_at < 0) begin
                load_at = k;
                sin_at_load = cpu_shift_in;
            end
            if (cpu_reg_sel !== r) sel_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                resp_at = k;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_reg = 2'd0; cmd_data = 8'h00;
        rsp_ready = 1'b0; cpu_sleep = 1'b0; cpu_stop = 1'b0;
        repeat (3) tick();
        total++;
        if ({cpu_run, cpu_step, cpu_load, cpu_dump, cpu_shift_in, cpu_reg_sel} !== 7'b0) begin
            bad++; $display("[TB] FAIL reset_cpu: got %b want 0000000",
                {cpu_run, cpu_step, cpu_load, cpu_dump, cpu_shift_in, cpu_reg_sel});
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_data} !== 10'b0) begin
            bad++; $display("[TB] FAIL reset_rsp: got %b want 0", {rsp_valid, rsp_err, rsp_data});
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        logic [7:0] bits; int load_at, resp_at; logic sel_ok, sin_l;
        run_write(2'd2, 8'hA5, bits, load_at, resp_at, sel_ok, sin_l);
        total++; if (bits !== 8'hA5) begin bad++; $display("[TB] FAIL write_bits: got %h want a5", bits); end
        total++; if (load_at != 9) begin bad++; $display("[TB] FAIL write_load_cycle: got %0d want 9", load_at); end
        total++; if (resp_at != 10) begin bad++; $display("[TB] FAIL write_resp_cycle: got %0d want 10", resp_at); end
        total++; if (sel_ok !== 1'b1) begin bad++; $display("[TB] FAIL write_reg_sel: got %b want 1", sel_ok); end
        total++; if (sin_l !== 1'b0) begin bad++; $display("[TB] FAIL write_shift_in_at_load: got %b want 0", sin_l); end
        total++; if ({rsp_err, rsp_data} !== 9'h000) begin
            bad++; $display("[TB] FAIL write_rsp: got %h want 000", {rsp_err, rsp_data});
        end
        handshake();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL write_back_idle: got %b want 1", cmd_ready); end
    endtask

    task automatic test_read(input logic [1:0] r, input logic [7:0] val);
        int dumps = 0; int resp_at = -1; logic sel_ok = 1'b1;
        model_val = val;
        issue(2'd1, r, 8'h55);
        for (int k = 1; k <= 20; k++) begin
            if (cpu_dump === 1'b1) dumps++;
            if (cpu_reg_sel !== r) sel_ok = 1'b0;
            if (rsp_valid === 1'b1) begin resp_at = k; break; end
            tick();
        end
        total++; if (dumps != 1) begin bad++; $display("[TB] FAIL read_dumps: got %0d want 1", dumps); end
        total++; if (resp_at != 10) begin bad++; $display("[TB] FAIL read_resp_cycle: got %0d want 10", resp_at); end
        total++; if (sel_ok !== 1'b1) begin bad++; $display("[TB] FAIL read_reg_sel: got %b want 1", sel_ok); end
        total++; if (rsp_data !== val) begin bad++; $display("[TB] FAIL read_data: got %h want %h", rsp_data, val); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL read_err: got %b want 0", rsp_err); end
        handshake();
    endtask

    task automatic test_step();
        cpu_sleep = 1'b1; cpu_stop = 1'b0;
        issue(2'd2, 2'd3, 8'h00);
        total++; if ({cpu_step, cpu_reg_sel, cpu_run} !== 4'b1110) begin
            bad++; $display("[TB] FAIL step_pulse: got %b want 1110", {cpu_step, cpu_reg_sel, cpu_run});
        end
        tick();
        total++; if ({cpu_step, rsp_valid, rsp_data} !== {2'b01, 8'h02}) begin
            bad++; $display("[TB] FAIL step_rsp: got %h want 102", {cpu_step, rsp_valid, rsp_data});
        end
        cpu_sleep = 1'b0;
        handshake();
    endtask

    task automatic test_run(input int stop_at);
        int run_cycles = 0;
        cpu_stop = 1'b0; cpu_sleep = 1'b0;
        issue(2'd3, 2'd0, 8'h00);
        for (int k = 0; k < 200; k++) begin
            if (cpu_run !== 1'b1) break;
            run_cycles++;
            if (run_cycles == stop_at) cpu_stop = 1'b1;
            tick();
        end
        total++; if (run_cycles != stop_at) begin
            bad++; $display("[TB] FAIL run_cycles: got %0d want %0d", run_cycles, stop_at);
        end
        total++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 8'h01}) begin
            bad++; $display("[TB] FAIL run_rsp: got %h want 201", {rsp_valid, rsp_err, rsp_data});
        end
        cpu_stop = 1'b0;
        handshake();
    endtask

    task automatic test_run_preset();
        cpu_stop = 1'b1; cpu_sleep = 1'b1;
        issue(2'd3, 2'd1, 8'h00);
        total++; if (cpu_run !== 1'b1) begin bad++; $display("[TB] FAIL preset_run_on: got %b want 1", cpu_run); end
        tick();
        total++; if ({cpu_run, rsp_valid, rsp_data} !== {2'b01, 8'h03}) begin
            bad++; $display("[TB] FAIL preset_rsp: got %h want 103", {cpu_run, rsp_valid, rsp_data});
        end
        cpu_stop = 1'b0; cpu_sleep = 1'b0;
        handshake();
    endtask

`ifdef SPELL_DBG_TIMEOUT_EN
    task automatic test_timeout();
        int run_cycles = 0;
        issue(2'd3, 2'd0, 8'h00);
        for (int k = 0; k < 200; k++) begin
            if (cpu_run !== 1'b1) break;
            run_cycles++;
            tick();
        end
        total++; if (run_cycles != 16) begin bad++; $display("[TB] FAIL timeout_cycles: got %0d want 16", run_cycles); end
        total++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 8'h00}) begin
            bad++; $display("[TB] FAIL timeout_rsp: got %h want 300", {rsp_valid, rsp_err, rsp_data});
        end
        handshake();
    endtask
`endif

    task automatic test_reset_midwrite();
        int loads_before;
        logic [7:0] bits; int load_at, resp_at; logic sel_ok, sin_l;
        issue(2'd0, 2'd1, 8'h5A);
        repeat (3) tick();
        loads_before = load_pulses;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({cpu_run, cpu_step, cpu_load, cpu_dump, cpu_shift_in, cpu_reg_sel, rsp_valid} !== 8'b0) begin
            bad++; $display("[TB] FAIL midreset_outputs: got %b want 0",
                {cpu_run, cpu_step, cpu_load, cpu_dump, cpu_shift_in, cpu_reg_sel, rsp_valid});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total++; if (load_pulses != loads_before) begin
            bad++; $display("[TB] FAIL midreset_no_load: got %0d want %0d", load_pulses, loads_before);
        end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_ready: got %b want 1", cmd_ready); end
        run_write(2'd0, 8'hFF, bits, load_at, resp_at, sel_ok, sin_l);
        total++; if ({bits, 8'(load_at), 8'(resp_at)} !== {8'hFF, 8'd9, 8'd10}) begin
            bad++; $display("[TB] FAIL midreset_rewrite: got %h/%0d/%0d want ff/9/10", bits, load_at, resp_at);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int waited;
        cpu_stop = 1'b1;
        issue(2'd2, 2'd0, 8'h00);
        tick();
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_reg = 2'd2; cmd_data = 8'h81;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp_valid, cmd_ready, rsp_err, rsp_data} !== {3'b100, 8'h01}) begin
                bad++; $display("[TB] FAIL stall_hold[%0d]: got %h want 401", i, {rsp_valid, cmd_ready, rsp_err, rsp_data});
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cpu_stop = 1'b0;
        total++; if ({cmd_ready, rsp_valid} !== 2'b10) begin
            bad++; $display("[TB] FAIL stall_release: got %b want 10", {cmd_ready, rsp_valid});
        end
        tick();
        cmd_valid = 1'b0;
        total++; if ({cmd_ready, cpu_shift_in, cpu_reg_sel} !== 4'b0110) begin
            bad++; $display("[TB] FAIL stall_next_accept: got %b want 0110", {cmd_ready, cpu_shift_in, cpu_reg_sel});
        end
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 20) begin tick(); waited++; end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_next_resp: got %b want 1", rsp_valid); end
        handshake();
    endtask

    task automatic test_exclusive();
        total++;
        if (overlap_hits != 0) begin bad++; $display("[TB] FAIL pulse_overlap: got %0d want 0", overlap_hits); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(2'd1, 8'h3C);
        test_read(2'd3, 8'hC1);
        test_step();
        test_run(RUN_STOP_AT);
        test_run_preset();
`ifdef SPELL_DBG_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midwrite();
        test_back_to_back();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
